jt1942_rom_arb: RTL and testbench

//  SDRAM-side responder for the video ROM fetch ports (char, scroll, object).
//  - Watches the three address buses driven by the video block.
//  - Issues one SDRAM word read per changed address, round-robin.
//  - Returns each result on the matching data bus.
//  - Holds a one-entry cache per slot, so unchanged addresses cost no SDRAM traffic.

---
 rtl/jt1942_rom_arb_if.sv | 33 +++
 rtl/jt1942_rom_arb.sv | 156 +++++++++++++++
 tb/tb_jt1942_rom_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt1942_rom_arb_if.sv
// Bundle of the video ROM fetch ports and the SDRAM read port seen by jt1942_rom_arb.
// The master side is the arbiter; the slave side is the video block plus SDRAM controller.
interface jt1942_rom_arb_if;
    logic        downloading;
    logic [11:0] char_addr;
    logic [15:0] char_data;
    logic        char_ok;
    logic [14:0] scr_addr;
    logic [23:0] scr_data;
    logic        scr_ok;
    logic [14:0] obj_addr;
    logic [15:0] obj_data;
    logic        obj_ok;
    // sdram_req is raised with a stable sdram_addr and held until a single-cycle
    // sdram_rdy pulse; sdram_data is valid only in that rdy cycle.
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_rdy;
    logic [31:0] sdram_data;
    logic        dbg_state;

    modport master (
        input  downloading, char_addr, scr_addr, obj_addr, sdram_rdy, sdram_data,
        output char_data, char_ok, scr_data, scr_ok, obj_data, obj_ok,
               sdram_req, sdram_addr, dbg_state
    );

    modport slave (
        output downloading, char_addr, scr_addr, obj_addr, sdram_rdy, sdram_data,
        input  char_data, char_ok, scr_data, scr_ok, obj_data, obj_ok,
               sdram_req, sdram_addr, dbg_state
    );
endinterface

// File: rtl/jt1942_rom_arb.sv
// Round-robin SDRAM reader for the char/scroll/object ROM ports, with a
// one-word cache per port so an unchanged address generates no SDRAM traffic.
module jt1942_rom_arb #(
    parameter logic [21:0] CHAR_OFF = 22'h00000,
    parameter logic [21:0] SCR_OFF  = 22'h02000,
    parameter logic [21:0] OBJ_OFF  = 22'h06000
) (
    input  logic             clk,
    input  logic             rst_n,
    jt1942_rom_arb_if.master bus
);

    typedef enum logic { IDLE, WAIT } state_t;
    typedef enum logic [1:0] { SLOT_CHAR = 2'd0, SLOT_SCR = 2'd1, SLOT_OBJ = 2'd2 } slot_t;

    state_t      state_q, state_d;
    slot_t       ptr_q, cur_q, pick;
    logic        pick_ok, start, done;
    logic [2:0]  valid_q, hit, pend;
    logic [11:0] char_last;
    logic [14:0] scr_last, obj_last, issue_addr, pick_addr;
    logic [21:0] pick_off;
    logic        dl_q;
    logic        unused_data_bits;

    assign unused_data_bits = ^bus.sdram_data[31:24];

    assign hit[0] = valid_q[0] & (bus.char_addr == char_last);
    assign hit[1] = valid_q[1] & (bus.scr_addr  == scr_last);
    assign hit[2] = valid_q[2] & (bus.obj_addr  == obj_last);
    assign pend   = ~hit;

    assign bus.char_ok   = hit[0];
    assign bus.scr_ok    = hit[1];
    assign bus.obj_ok    = hit[2];
    assign bus.dbg_state = (state_q == WAIT);

    // Search starts at the slot after the last one served, so no slot starves.
    always_comb begin
        pick    = ptr_q;
        pick_ok = 1'b1;
        case (ptr_q)
            SLOT_CHAR: begin
                if      (pend[1]) pick = SLOT_SCR;
                else if (pend[2]) pick = SLOT_OBJ;
                else if (pend[0]) pick = SLOT_CHAR;
                else              pick_ok = 1'b0;
            end
            SLOT_SCR: begin
                if      (pend[2]) pick = SLOT_OBJ;
                else if (pend[0]) pick = SLOT_CHAR;
                else if (pend[1]) pick = SLOT_SCR;
                else              pick_ok = 1'b0;
            end
            default: begin
                if      (pend[0]) pick = SLOT_CHAR;
                else if (pend[1]) pick = SLOT_SCR;
                else if (pend[2]) pick = SLOT_OBJ;
                else              pick_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        pick_addr = bus.obj_addr;
        pick_off  = OBJ_OFF;
        case (pick)
            SLOT_CHAR: begin
                pick_addr = {3'd0, bus.char_addr};
                pick_off  = CHAR_OFF;
            end
            SLOT_SCR: begin
                pick_addr = bus.scr_addr;
                pick_off  = SCR_OFF;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.downloading && pick_ok) begin
                    state_d = WAIT;
                    start   = 1'b1;
                end
            end
            WAIT: begin
                if (bus.sdram_rdy) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sdram_req  <= 1'b0;
            bus.sdram_addr <= 22'd0;
            bus.char_data  <= 16'd0;
            bus.scr_data   <= 24'd0;
            bus.obj_data   <= 16'd0;
            valid_q        <= 3'b000;
            char_last      <= 12'd0;
            scr_last       <= 15'd0;
            obj_last       <= 15'd0;
            issue_addr     <= 15'd0;
            ptr_q          <= SLOT_CHAR;
            cur_q          <= SLOT_CHAR;
            dl_q           <= 1'b0;
        end else begin
            dl_q <= bus.downloading;
            if (start) begin
                bus.sdram_req  <= 1'b1;
                bus.sdram_addr <= pick_off + {7'd0, pick_addr};
                issue_addr     <= pick_addr;
                cur_q          <= pick;
            end
            // Data is tagged with the address that was issued, not the live one.
            if (done) begin
                bus.sdram_req <= 1'b0;
                ptr_q         <= cur_q;
                case (cur_q)
                    SLOT_CHAR: begin
                        bus.char_data <= bus.sdram_data[15:0];
                        char_last     <= issue_addr[11:0];
                        valid_q[0]    <= 1'b1;
                    end
                    SLOT_SCR: begin
                        bus.scr_data <= bus.sdram_data[23:0];
                        scr_last     <= issue_addr;
                        valid_q[1]   <= 1'b1;
                    end
                    default: begin
                        bus.obj_data <= bus.sdram_data[15:0];
                        obj_last     <= issue_addr;
                        valid_q[2]   <= 1'b1;
                    end
                endcase
            end
            // A finished download invalidates everything, even a fetch landing now.
            if (dl_q && !bus.downloading) valid_q <= 3'b000;
        end
    end

endmodule

// File: tb/tb_jt1942_rom_arb.sv
// Randomized bench for jt1942_rom_arb: SDRAM responder, cycle-level reference
// model of the cache/arbiter rules, directed scenarios and a random phase.
module tb_jt1942_rom_arb;

    logic clk;
    logic rst_n;
    jt1942_rom_arb_if bus();

    jt1942_rom_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- SDRAM contents ----------------
    logic [31:0] salt;
    logic [31:0] mem_ovr [logic [21:0]];

    function automatic logic [31:0] mem_fn(input logic [21:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return {a[9:0], a} ^ salt;
    endfunction

    // ---------------- SDRAM responder ----------------
    bit hold    = 1'b0;
    bit spur_en = 1'b0;
    int rsp_cnt = 0;
    bit was_req = 1'b0;

    initial begin
        bus.sdram_rdy  = 1'b0;
        bus.sdram_data = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            bus.sdram_rdy  = 1'b0;
            bus.sdram_data = $urandom;
            if (!rst_n) begin
                was_req = 1'b0;
            end else if (bus.sdram_req) begin
                if (!was_req) rsp_cnt = $urandom_range(0, 4);
                was_req = 1'b1;
                if (!hold) begin
                    if (rsp_cnt == 0) begin
                        bus.sdram_rdy  = 1'b1;
                        bus.sdram_data = mem_fn(bus.sdram_addr);
                    end else begin
                        rsp_cnt--;
                    end
                end
            end else begin
                was_req = 1'b0;
                if (spur_en && $urandom_range(0, 5) == 0) bus.sdram_rdy = 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    // Slots: 0 char, 1 scroll, 2 object.
    bit          m_valid [3];
    logic [14:0] m_tag   [3];
    logic [31:0] m_data  [3];
    int          m_ptr;
    bit          m_dl_q;
    int          out_slot;
    logic [21:0] out_addr;
    logic [14:0] out_tag;
    logic [21:0] req_log [$];
    logic [21:0] exp_q [$];

    bit          p_req, p_rdy, p_dl, in_rst;
    logic [14:0] p_addr [3];

    function automatic logic [21:0] off_of(input int s);
        case (s)
            0:       return 22'h00000;
            1:       return 22'h02000;
            default: return 22'h06000;
        endcase
    endfunction

    function automatic logic [14:0] live_addr(input int s);
        case (s)
            0:       return {3'd0, bus.char_addr};
            1:       return bus.scr_addr;
            default: return bus.obj_addr;
        endcase
    endfunction

    function automatic bit slot_pend(input int s, input logic [14:0] a);
        return !m_valid[s] || (m_tag[s] != a);
    endfunction

    function automatic bit any_pend_live();
        for (int s = 0; s < 3; s++)
            if (slot_pend(s, live_addr(s))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            m_valid[s] = 1'b0;
            m_tag[s]   = 15'd0;
            m_data[s]  = 32'd0;
        end
        m_ptr  = 0;
        m_dl_q = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req"},   {31'd0, bus.sdram_req}, 32'd0);
        check({tag, "_addr"},  {10'd0, bus.sdram_addr}, 32'd0);
        check({tag, "_cdata"}, {16'd0, bus.char_data}, 32'd0);
        check({tag, "_sdata"}, {8'd0, bus.scr_data}, 32'd0);
        check({tag, "_odata"}, {16'd0, bus.obj_data}, 32'd0);
        check({tag, "_oks"},   {29'd0, bus.char_ok, bus.scr_ok, bus.obj_ok}, 32'd0);
    endtask

    // Every falling edge: judge the transition made at the preceding rising edge
    // using the inputs that were held at that edge, then check the live outputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
            check_outputs_zero("rst");
            in_rst = 1'b1;
        end else if (in_rst) begin
            in_rst = 1'b0;
            check("post_rst_req", {31'd0, bus.sdram_req}, 32'd0);
        end else begin
            if (!p_req) begin
                bit exp_start;
                int sel;
                exp_start = 1'b0;
                sel = 0;
                if (!p_dl) begin
                    for (int k = 1; k <= 3; k++) begin
                        int s;
                        s = (m_ptr + k) % 3;
                        if (!exp_start && slot_pend(s, p_addr[s])) begin
                            exp_start = 1'b1;
                            sel = s;
                        end
                    end
                end
                check("req_start", {31'd0, bus.sdram_req}, {31'd0, exp_start});
                if (exp_start) begin
                    out_slot = sel;
                    out_tag  = p_addr[sel];
                    out_addr = off_of(sel) + {7'd0, p_addr[sel]};
                    check("req_addr", {10'd0, bus.sdram_addr}, {10'd0, out_addr});
                    req_log.push_back(bus.sdram_addr);
                end
            end else if (p_rdy) begin
                check("req_drop", {31'd0, bus.sdram_req}, 32'd0);
                m_valid[out_slot] = 1'b1;
                m_tag[out_slot]   = out_tag;
                m_data[out_slot]  = mem_fn(out_addr);
                m_ptr             = out_slot;
            end else begin
                check("req_hold", {31'd0, bus.sdram_req}, 32'd1);
                check("addr_hold", {10'd0, bus.sdram_addr}, {10'd0, out_addr});
            end
            if (m_dl_q && !p_dl)
                for (int s = 0; s < 3; s++) m_valid[s] = 1'b0;
            m_dl_q = p_dl;

            check("char_ok", {31'd0, bus.char_ok}, {31'd0, !slot_pend(0, live_addr(0))});
            check("scr_ok",  {31'd0, bus.scr_ok},  {31'd0, !slot_pend(1, live_addr(1))});
            check("obj_ok",  {31'd0, bus.obj_ok},  {31'd0, !slot_pend(2, live_addr(2))});
            check("char_data", {16'd0, bus.char_data}, {16'd0, m_data[0][15:0]});
            check("scr_data",  {8'd0, bus.scr_data},   {8'd0, m_data[1][23:0]});
            check("obj_data",  {16'd0, bus.obj_data},  {16'd0, m_data[2][15:0]});
        end
        p_req = bus.sdram_req;
        p_rdy = bus.sdram_rdy;
        p_dl  = bus.downloading;
        for (int s = 0; s < 3; s++) p_addr[s] = live_addr(s);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        bit done_w;
        done_w = 1'b0;
        for (int i = 0; i < 300 && !done_w; i++) begin
            @(negedge clk);
            #1;
            if (!bus.sdram_req && !bus.downloading && !any_pend_live()) done_w = 1'b1;
        end
        if (!done_w) check({tag, "_idle_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_req(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (bus.sdram_req) seen = 1'b1;
        end
        if (!seen) check({tag, "_req_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_count"}, req_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < req_log.size(); i++)
            check({tag, "_addr"}, {10'd0, req_log[i]}, {10'd0, exp_q[i]});
        req_log.delete();
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        salt = $urandom;
        model_reset();
        in_rst = 1'b1;
        rst_n = 1'b0;
        bus.downloading = 1'b0;
        bus.char_addr = 12'h123;
        bus.scr_addr  = 15'h0000;
        bus.obj_addr  = 15'h0000;
        mem_ovr[22'h000123] = 32'hDEADBEEF;
        mem_ovr[22'h002010] = 32'h11ABCDEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset_state");
        step();
        rst_n = 1'b1;

        // 1: after reset every slot is empty; rotation starts after CHAR.
        wait_idle("t1");
        exp_q.push_back(22'h002000);
        exp_q.push_back(22'h006000);
        exp_q.push_back(22'h000123);
        check_log("t1");
        check("t1_char_data", {16'd0, bus.char_data}, 32'h0000BEEF);
        check("t1_char_ok", {31'd0, bus.char_ok}, 32'd1);

        // 2: one scroll change -> exactly one fetch.
        step();
        bus.scr_addr = 15'h0010;
        wait_idle("t2");
        exp_q.push_back(22'h002010);
        check_log("t2");
        check("t2_scr_data", {8'd0, bus.scr_data}, 32'h00ABCDEF);
        check("t2_scr_ok", {31'd0, bus.scr_ok}, 32'd1);

        // 3: all change together; last served was SCR, so OBJ, CHAR, SCR.
        step();
        bus.char_addr = 12'h456;
        bus.scr_addr  = 15'h1234;
        bus.obj_addr  = 15'h7FFF;
        wait_idle("t3");
        exp_q.push_back(22'h00DFFF);
        exp_q.push_back(22'h000456);
        exp_q.push_back(22'h003234);
        check_log("t3");

        // 4: object address moves while its fetch is outstanding.
        step();
        hold = 1'b1;
        bus.obj_addr = 15'h0001;
        wait_req("t4");
        step();
        step();
        bus.obj_addr = 15'h0002;
        @(negedge clk);
        #1;
        check("t4_ok_during_wait", {31'd0, bus.obj_ok}, 32'd0);
        step();
        hold = 1'b0;
        wait_idle("t4");
        exp_q.push_back(22'h006001);
        exp_q.push_back(22'h006002);
        check_log("t4");
        check("t4_obj_ok", {31'd0, bus.obj_ok}, 32'd1);

        // 5: downloading blocks requests; its end forces a full refetch.
        step();
        bus.downloading = 1'b1;
        bus.char_addr = 12'h321;
        repeat (10) step();
        check("t5_no_req_count", req_log.size(), 32'd0);
        bus.downloading = 1'b0;
        wait_idle("t5");
        check("t5_refetch_count", req_log.size(), 32'd3);
        req_log.delete();

        // 6: reset asserted in the middle of a fetch.
        step();
        hold = 1'b1;
        bus.scr_addr = 15'h4000;
        wait_req("t6");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t6_async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold = 1'b0;
        wait_idle("t6");
        req_log.delete();

        // Random phase: small address sets to exercise cache hits, spurious rdy,
        // occasional download windows.
        spur_en = 1'b1;
        for (int it = 0; it < 300; it++) begin
            step();
            if ($urandom_range(0, 2) == 0)
                bus.char_addr = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 3)) : 12'($urandom);
            if ($urandom_range(0, 2) == 0)
                bus.scr_addr = ($urandom_range(0, 1) == 0) ? 15'($urandom_range(0, 3)) : 15'($urandom);
            if ($urandom_range(0, 2) == 0)
                bus.obj_addr = ($urandom_range(0, 1) == 0) ? 15'($urandom_range(0, 3)) : 15'($urandom);
            if (bus.downloading) begin
                if ($urandom_range(0, 3) == 0) bus.downloading = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                bus.downloading = 1'b1;
            end
            repeat ($urandom_range(0, 6)) step();
        end
        step();
        bus.downloading = 1'b0;
        spur_en = 1'b0;
        wait_idle("rand_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
